uop_retire_tracker: RTL and testbench

//  Writeback-stage companion to the decode micro-op expander. Decode splits one

---
 rtl/uop_retire_tracker.sv | 190 +++++++++++++++++++
 tb/tb_uop_retire_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uop_retire_tracker.sv
// Writeback-side micro-op group tracker: folds each decoded micro-op group back into
// one architectural retire event with atomic NZCV commit, flush discard and protocol checking.
module uop_retire_tracker #(
  parameter int         MAX_UOPS    = 4,
  parameter int         CNTW        = 3,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidW,
  input  logic            uOpFirstW,
  input  logic            uOpLastW,
  input  logic            CondExW,
  input  logic            FlagWriteW,
  input  logic [3:0]      FlagsW,
  input  logic            KeepVW,
  input  logic [31:0]     PCW,
  input  logic            FlushW,
  output logic            RetireW,
  output logic [31:0]     RetirePCW,
  output logic [CNTW-1:0] RetireCntW,
  output logic [3:0]      ArchFlags,
  output logic            GroupActive,
  output logic            ProtocolErr
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GROUP = 1'b1
  } state_e;

  // Fold one micro-op's flag effect onto a base NZCV value; V may be carried through.
  function automatic logic [3:0] apply_flags(
    input logic [3:0] base,
    input logic       upd,
    input logic       keep_v,
    input logic [3:0] flags
  );
    logic [3:0] res;
    if (upd) begin
      res = {flags[3:1], (keep_v ? base[0] : flags[0])};
    end else begin
      res = base;
    end
    return res;
  endfunction

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_UOPS);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      arch_q, arch_d;
  logic            retire_q, retire_d;
  logic [31:0]     retire_pc_q, retire_pc_d;
  logic [CNTW-1:0] retire_cnt_q, retire_cnt_d;
  logic            active_q, active_d;
  logic            err_q, err_d;

  logic            flag_upd_s;
  logic            start_s;
  logic            misplaced_s;
  logic [CNTW-1:0] cnt_inc_s;

  assign flag_upd_s = CondExW & FlagWriteW;
  assign cnt_inc_s  = cnt_q + CNT_ONE;

  // A micro-op starts a fresh group when nothing is open, or when a First arrives mid-group.
  always_comb begin
    start_s     = 1'b0;
    misplaced_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_s     = 1'b1;
        misplaced_s = ~uOpFirstW;
      end
      S_GROUP: begin
        start_s     = uOpFirstW;
        misplaced_s = uOpFirstW;
      end
      default: begin
        start_s     = 1'b1;
        misplaced_s = 1'b1;
      end
    endcase
  end

  // Next-state, group bookkeeping and retire/commit decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    arch_d       = arch_q;
    retire_d     = 1'b0;
    retire_pc_d  = retire_pc_q;
    retire_cnt_d = retire_cnt_q;
    err_d        = err_q;

    if (FlushW) begin
      state_d = S_IDLE;
      cnt_d   = {CNTW{1'b0}};
      pend_d  = arch_q;
    end else if (ValidW) begin
      if (misplaced_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end

      if (start_s) begin
        // Any open group is abandoned; the new one is seeded from committed flags.
        if (uOpLastW) begin
          state_d      = S_IDLE;
          cnt_d        = {CNTW{1'b0}};
          arch_d       = apply_flags(arch_q, flag_upd_s, KeepVW, FlagsW);
          pend_d       = arch_d;
          retire_d     = 1'b1;
          retire_pc_d  = PCW;
          retire_cnt_d = CNT_ONE;
        end else begin
          state_d = S_GROUP;
          cnt_d   = CNT_ONE;
          pc_d    = PCW;
          pend_d  = apply_flags(arch_q, flag_upd_s, KeepVW, FlagsW);
        end
      end else begin
        if (uOpLastW) begin
          state_d      = S_IDLE;
          cnt_d        = {CNTW{1'b0}};
          arch_d       = apply_flags(pend_q, flag_upd_s, KeepVW, FlagsW);
          pend_d       = arch_d;
          retire_d     = 1'b1;
          retire_pc_d  = pc_q;
          retire_cnt_d = cnt_inc_s;
        end else if (cnt_inc_s == CNT_MAX) begin
          // A non-last micro-op filling the last slot can never be closed legally.
          state_d = S_IDLE;
          cnt_d   = {CNTW{1'b0}};
          pend_d  = arch_q;
          err_d   = 1'b1;
        end else begin
          cnt_d  = cnt_inc_s;
          pend_d = apply_flags(pend_q, flag_upd_s, KeepVW, FlagsW);
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  assign active_d = (state_d == S_GROUP);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNTW{1'b0}};
      pc_q         <= 32'h0000_0000;
      pend_q       <= FLAGS_RESET;
      arch_q       <= FLAGS_RESET;
      retire_q     <= 1'b0;
      retire_pc_q  <= 32'h0000_0000;
      retire_cnt_q <= {CNTW{1'b0}};
      active_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      arch_q       <= arch_d;
      retire_q     <= retire_d;
      retire_pc_q  <= retire_pc_d;
      retire_cnt_q <= retire_cnt_d;
      active_q     <= active_d;
      err_q        <= err_d;
    end
  end

  assign RetireW     = retire_q;
  assign RetirePCW   = retire_pc_q;
  assign RetireCntW  = retire_cnt_q;
  assign ArchFlags   = arch_q;
  assign GroupActive = active_q;
  assign ProtocolErr = err_q;

endmodule

// File: tb/tb_uop_retire_tracker.sv
// Randomized bench for uop_retire_tracker against a queue-based group model.
module tb_uop_retire_tracker;

  localparam int         MAX  = 4;
  localparam int         CW   = 3;
  localparam logic [3:0] FRST = 4'b0000;

  logic          clk;
  logic          reset;
  logic          ValidW, uOpFirstW, uOpLastW, CondExW, FlagWriteW, KeepVW, FlushW;
  logic [3:0]    FlagsW;
  logic [31:0]   PCW;
  logic          RetireW;
  logic [31:0]   RetirePCW;
  logic [CW-1:0] RetireCntW;
  logic [3:0]    ArchFlags;
  logic          GroupActive;
  logic          ProtocolErr;

  uop_retire_tracker #(.MAX_UOPS(MAX), .CNTW(CW), .FLAGS_RESET(FRST)) dut (
    .clk(clk), .reset(reset), .ValidW(ValidW), .uOpFirstW(uOpFirstW),
    .uOpLastW(uOpLastW), .CondExW(CondExW), .FlagWriteW(FlagWriteW),
    .FlagsW(FlagsW), .KeepVW(KeepVW), .PCW(PCW), .FlushW(FlushW),
    .RetireW(RetireW), .RetirePCW(RetirePCW), .RetireCntW(RetireCntW),
    .ArchFlags(ArchFlags), .GroupActive(GroupActive), .ProtocolErr(ProtocolErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: the open group is a list of recorded micro-ops {CondEx,FlagWrite,KeepV,Flags}.
  logic [6:0]  grp[$];
  logic        m_open;
  logic [31:0] m_gpc;
  logic [3:0]  m_arch;
  logic        m_err;
  logic        m_ret;
  logic [31:0] m_rpc;
  int          m_rcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    grp.delete();
    m_open = 1'b0; m_gpc = 32'h0; m_arch = FRST; m_err = 1'b0;
    m_ret = 1'b0; m_rpc = 32'h0; m_rcnt = 0;
  endtask

  task automatic model_retire();
    logic [3:0] f;
    f = m_arch;
    foreach (grp[i]) begin
      if (grp[i][6] && grp[i][5]) f = {grp[i][3:1], (grp[i][4] ? f[0] : grp[i][0])};
    end
    m_arch = f;
    m_ret  = 1'b1;
    m_rpc  = m_gpc;
    m_rcnt = grp.size();
    grp.delete();
    m_open = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic l, input logic c,
                            input logic fw, input logic kv, input logic [3:0] fl,
                            input logic [31:0] pc, input logic fsh);
    m_ret = 1'b0;
    if (fsh) begin
      grp.delete();
      m_open = 1'b0;
    end else if (v) begin
      if (!m_open || f) begin
        if (m_open == f) m_err = 1'b1;
        grp.delete();
        m_gpc = pc;
        grp.push_back({c, fw, kv, fl});
        if (l) model_retire();
        else   m_open = 1'b1;
      end else begin
        grp.push_back({c, fw, kv, fl});
        if (l) model_retire();
        else if (grp.size() == MAX) begin
          m_err = 1'b1;
          grp.delete();
          m_open = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".RetireW"}, 32'(RetireW), 32'(m_ret));
    check_val({tag, ".ArchFlags"}, 32'(ArchFlags), 32'(m_arch));
    check_val({tag, ".GroupActive"}, 32'(GroupActive), 32'(m_open));
    check_val({tag, ".ProtocolErr"}, 32'(ProtocolErr), 32'(m_err));
    if (m_ret) begin
      check_val({tag, ".RetirePCW"}, RetirePCW, m_rpc);
      check_val({tag, ".RetireCntW"}, 32'(RetireCntW), 32'(m_rcnt));
    end
  endtask

  task automatic step(input string tag, input logic v, input logic f, input logic l,
                      input logic c, input logic fw, input logic kv, input logic [3:0] fl,
                      input logic [31:0] pc, input logic fsh);
    ValidW = v; uOpFirstW = f; uOpLastW = l; CondExW = c; FlagWriteW = fw;
    KeepVW = kv; FlagsW = fl; PCW = pc; FlushW = fsh;
    @(posedge clk);
    #1;
    model_step(v, f, l, c, fw, kv, fl, pc, fsh);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int          n;
    logic        fsh;
    ValidW = 1'b0; uOpFirstW = 1'b0; uOpLastW = 1'b0; CondExW = 1'b0; FlagWriteW = 1'b0;
    KeepVW = 1'b0; FlagsW = 4'h0; PCW = 32'h0; FlushW = 1'b0;
    reset = 1'b0;
    #2;
    do_reset();

    // single-uOp instruction
    step("single", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h100, 1'b0);
    idle("single_after");
    // RSR pair
    step("rsr1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h200, 1'b0);
    step("rsr2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 32'h200, 1'b0);
    idle("rsr_after");
    // MLA keeping V
    step("setv", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 32'h300, 1'b0);
    step("mla1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h304, 1'b0);
    step("mla2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 32'h304, 1'b0);
    // flush mid-group
    step("fl1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h400, 1'b0);
    step("fl2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 32'h400, 1'b1);
    idle("fl_after");
    // exactly MAX uOps is legal
    step("max1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 32'h480, 1'b0);
    step("max2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h480, 1'b0);
    step("max3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 32'h480, 1'b0);
    step("max4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h480, 1'b0);

    // random well-formed groups with gaps and flushes
    for (int g = 0; g < 60; g++) begin
      n  = $urandom_range(1, MAX);
      pc = $urandom & 32'hFFFF_FFFC;
      for (int k = 0; k < n; k++) begin
        while ($urandom_range(0, 3) == 0) idle("rgap");
        fsh = ($urandom_range(0, 11) == 0);
        step("rlegal", 1'b1, (k == 0), (k == n - 1), 1'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom), pc, fsh);
        if (fsh) break;
      end
    end

    // protocol errors: stray non-first uOp, then overrun
    step("stray", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 32'h500, 1'b0);
    step("ov1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 32'h600, 1'b0);
    for (int k = 0; k < MAX - 1; k++)
      step("ovn", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 32'h600, 1'b0);
    idle("ov_after");
    idle("err_sticky");

    // fully random traffic
    for (int i = 0; i < 300; i++) begin
      step("rany", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 15) == 0));
    end

    // async reset between edges with a group open
    do_reset();
    step("ar1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1110, 32'h700, 1'b0);
    step("ar2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, 32'h704, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async");
    check_val("async.RetirePCW", RetirePCW, 32'h0);
    check_val("async.RetireCntW", 32'(RetireCntW), 32'h0);
    #2;
    reset = 1'b0;
    step("post_ar", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h708, 1'b0);
    idle("post_ar_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
